// File: rtl/delay_pipe_sched_if.sv
// Handshake bundle between the per-channel sample sources, the shared delay
// pipeline scheduler and the downstream consumer of the delayed words.
// The master side is the environment: it drives requests and downstream ready.
// The slave side is the scheduler: it drives grants and the pipeline output.
interface delay_pipe_sched_if #(
    parameter int NUM_CHAN  = 4,
    parameter int NUM_BITS  = 24,
    parameter int CHAN_BITS = 2
);
    logic [NUM_CHAN-1:0]          req_valid;
    logic [NUM_CHAN*NUM_BITS-1:0] req_data;
    logic [NUM_CHAN-1:0]          req_ready;
    logic                         out_valid;
    logic [CHAN_BITS-1:0]         out_chan;
    logic [NUM_BITS-1:0]          out_data;
    logic                         out_ready;

    modport master (
        output req_valid,
        output req_data,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_chan,
        input  out_data
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_chan,
        output out_data
    );
endinterface

// File: rtl/delay_pipe_sched.sv
// Round-robin scheduler feeding one shared fixed-latency delay pipeline.
// Each granted word carries its channel tag through NUM_CYCLES stages and
// leaves from the last stage. The pipeline only moves when the output slot is
// empty or being accepted, so a downstream stall freezes every stage and also
// blocks new grants. An IDLE/RUN/FLUSH controller gates grants and reports
// the end of a drain with a one-cycle flush_done pulse.
module delay_pipe_sched #(
    parameter int NUM_CHAN   = 4,
    parameter int NUM_BITS   = 24,
    parameter int NUM_CYCLES = 8,
    parameter int CHAN_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [NUM_CHAN-1:0]   chan_mask,
    delay_pipe_sched_if.slave     bus,
    output logic                  busy,
    output logic                  flush_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [NUM_CYCLES-1:0] stage_v;
    logic [CHAN_BITS-1:0]  stage_chan [NUM_CYCLES];
    logic [NUM_BITS-1:0]   stage_data [NUM_CYCLES];

    logic [CHAN_BITS-1:0]  last_grant;
    logic [NUM_CHAN-1:0]   eligible;
    logic [NUM_CHAN-1:0]   grant_vec;
    logic [CHAN_BITS-1:0]  winner;
    logic [NUM_BITS-1:0]   winner_data;
    logic                  winner_hit;
    logic                  grant_ok;
    logic                  grant_fire;
    logic                  adv;

    // The last stage is the output register; everything else is derived from it.
    assign bus.out_valid = stage_v[NUM_CYCLES-1];
    assign bus.out_chan  = stage_chan[NUM_CYCLES-1];
    assign bus.out_data  = stage_data[NUM_CYCLES-1];

    assign adv        = !stage_v[NUM_CYCLES-1] || bus.out_ready;
    assign busy       = |stage_v;
    assign eligible   = bus.req_valid & ~chan_mask;
    assign grant_fire = grant_ok && winner_hit;
    assign bus.req_ready = grant_vec;

    // Controller state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Controller transitions: flush always wins, and FLUSH is left only once the
    // pipeline is empty and the flush request has been released.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (flush) begin
                    state_nxt = FLUSH;
                end else if (enable) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt = FLUSH;
                end else if (!enable) begin
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if (!busy && !flush) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Controller outputs: grant permission and the drain-complete pulse.
    always_comb begin
        grant_ok   = 1'b0;
        flush_done = 1'b0;
        if (!reset) begin
            grant_ok   = (state == RUN) && !flush && enable && adv;
            flush_done = (state == FLUSH) && !busy && !flush;
        end
    end

    // Round-robin search: channels above last_grant first, then wrap to the
    // channels at or below it, so the previous winner is considered last.
    always_comb begin
        winner_hit  = 1'b0;
        winner      = '0;
        winner_data = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (!winner_hit && eligible[i] && (CHAN_BITS'(i) > last_grant)) begin
                winner_hit  = 1'b1;
                winner      = CHAN_BITS'(i);
                winner_data = bus.req_data[i*NUM_BITS +: NUM_BITS];
            end
        end
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (!winner_hit && eligible[i] && (CHAN_BITS'(i) <= last_grant)) begin
                winner_hit  = 1'b1;
                winner      = CHAN_BITS'(i);
                winner_data = bus.req_data[i*NUM_BITS +: NUM_BITS];
            end
        end
    end

    // One-hot ready toward the sources, all zero whenever no grant is issued.
    always_comb begin
        grant_vec = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            grant_vec[i] = grant_fire && (CHAN_BITS'(i) == winner);
        end
    end

    // Round-robin pointer moves only when a word is actually handed out.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= CHAN_BITS'(NUM_CHAN - 1);
        end else if (grant_fire) begin
            last_grant <= winner;
        end
    end

    // Delay line: shift every stage together on an advancing cycle, with the
    // current grant (or a bubble) entering stage 0; hold everything otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_v <= '0;
            for (int i = 0; i < NUM_CYCLES; i++) begin
                stage_chan[i] <= '0;
                stage_data[i] <= '0;
            end
        end else if (adv) begin
            for (int i = NUM_CYCLES - 1; i > 0; i--) begin
                stage_v[i]    <= stage_v[i-1];
                stage_chan[i] <= stage_chan[i-1];
                stage_data[i] <= stage_data[i-1];
            end
            stage_v[0]    <= grant_fire;
            stage_chan[0] <= grant_fire ? winner : '0;
            stage_data[0] <= grant_fire ? winner_data : '0;
        end
    end

endmodule

// File: tb/tb_delay_pipe_sched.sv
// Testbench for delay_pipe_sched: directed stimulus with hand-computed grant
// patterns; every grant pushes the expected output word into a scoreboard
// queue and an independent monitor pops and compares when words leave.
module tb_delay_pipe_sched;

    localparam int NUM_CHAN   = 4;
    localparam int NUM_BITS   = 24;
    localparam int NUM_CYCLES = 8;
    localparam int CHAN_BITS  = 2;

    typedef struct {
        logic [CHAN_BITS-1:0] chan;
        logic [NUM_BITS-1:0]  data;
        int                   cyc;
        int                   stalls;
    } exp_t;

    logic                clk;
    logic                reset;
    logic                enable;
    logic                flush;
    logic [NUM_CHAN-1:0] chan_mask;
    logic                busy;
    logic                flush_done;

    int   checks;
    int   errors;
    int   cyc;
    int   seq;
    int   stall_total;
    exp_t sb_q[$];

    logic                fixed_en;
    logic [NUM_BITS-1:0] fixed_data;

    logic [3:0] rr_all  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] rr_mask [6] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
    logic [3:0] rr_pre  [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] rr_post [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};

    delay_pipe_sched_if #(
        .NUM_CHAN (NUM_CHAN),
        .NUM_BITS (NUM_BITS),
        .CHAN_BITS(CHAN_BITS)
    ) bus_if ();

    delay_pipe_sched #(
        .NUM_CHAN  (NUM_CHAN),
        .NUM_BITS  (NUM_BITS),
        .NUM_CYCLES(NUM_CYCLES),
        .CHAN_BITS (CHAN_BITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .flush     (flush),
        .chan_mask (chan_mask),
        .bus       (bus_if),
        .busy      (busy),
        .flush_done(flush_done)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure each word's latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive one cycle of inputs, check the grant and record the expected word.
    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] mask, input logic en,
                                 input logic fl, input logic rdy, input logic [3:0] exp_ready);
        logic [NUM_BITS-1:0] words [NUM_CHAN];
        exp_t e;
        @(negedge clk);
        seq++;
        reset     = 1'b0;
        enable    = en;
        flush     = fl;
        chan_mask = mask;
        bus_if.req_valid = valid;
        bus_if.out_ready = rdy;
        for (int i = 0; i < NUM_CHAN; i++) begin
            words[i] = fixed_en ? fixed_data : {4'(i), 4'h5, 16'(seq)};
            bus_if.req_data[i*NUM_BITS +: NUM_BITS] = words[i];
        end
        #1;
        checkOutput("req_ready", 32'(bus_if.req_ready), 32'(exp_ready));
        if (exp_ready != 4'b0000) begin
            e.chan = '0;
            e.data = '0;
            for (int i = 0; i < NUM_CHAN; i++) begin
                if (exp_ready[i]) begin
                    e.chan = CHAN_BITS'(i);
                    e.data = words[i];
                end
            end
            e.cyc    = cyc;
            e.stalls = stall_total;
            sb_q.push_back(e);
        end
        if (!rdy) begin
            stall_total++;
        end
    endtask

    task automatic idleCycles(input int n, input logic en);
        for (int k = 0; k < n; k++) begin
            applyStimulus(4'b0000, 4'b0000, en, 1'b0, 1'b1, 4'b0000);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset     = 1'b1;
        enable    = 1'b0;
        flush     = 1'b0;
        chan_mask = '0;
        bus_if.req_valid = '0;
        bus_if.out_ready = 1'b1;
        sb_q.delete();
        @(negedge clk);
    endtask

    // Monitor: compare every word leaving the pipeline against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && bus_if.out_valid) begin
                if (sb_q.size() == 0) begin
                    checkOutput("spurious_out_valid", 32'(bus_if.out_valid), 32'd0);
                end else if (bus_if.out_ready) begin
                    e = sb_q.pop_front();
                    checkOutput("out_chan", 32'(bus_if.out_chan), 32'(e.chan));
                    checkOutput("out_data", 32'(bus_if.out_data), 32'(e.data));
                    checkOutput("latency", 32'(cyc - e.cyc), 32'(NUM_CYCLES + stall_total - e.stalls));
                end else begin
                    checkOutput("stall_hold_chan", 32'(bus_if.out_chan), 32'(sb_q[0].chan));
                    checkOutput("stall_hold_data", 32'(bus_if.out_data), 32'(sb_q[0].data));
                end
            end
        end
    end

    // Directed test sequence.
    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        seq         = 0;
        stall_total = 0;
        fixed_en    = 1'b0;
        fixed_data  = '0;
        reset       = 1'b1;
        enable      = 1'b0;
        flush       = 1'b0;
        chan_mask   = '0;
        bus_if.req_valid = '0;
        bus_if.req_data  = '0;
        bus_if.out_ready = 1'b1;

        $display("[TB] reset values");
        doReset();
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000);
        checkOutput("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        checkOutput("rst_out_chan", 32'(bus_if.out_chan), 32'd0);
        checkOutput("rst_out_data", 32'(bus_if.out_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_flush_done", 32'(flush_done), 32'd0);

        $display("[TB] single word on channel 2");
        fixed_en   = 1'b1;
        fixed_data = 24'hABCDEF;
        applyStimulus(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000);
        applyStimulus(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0100);
        fixed_en   = 1'b0;
        idleCycles(11, 1'b1);

        $display("[TB] all channels round robin");
        doReset();
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, rr_all[k]);
        end
        idleCycles(11, 1'b1);

        $display("[TB] channel 1 masked");
        doReset();
        applyStimulus(4'b1111, 4'b0010, 1'b1, 1'b0, 1'b1, 4'b0000);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b1111, 4'b0010, 1'b1, 1'b0, 1'b1, rr_mask[k]);
        end
        idleCycles(11, 1'b1);

        $display("[TB] downstream stall mid-stream");
        doReset();
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, rr_pre[k]);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, rr_post[k]);
        end
        idleCycles(14, 1'b1);

        $display("[TB] flush after five words");
        doReset();
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, rr_all[k]);
        end
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000);
        checkOutput("flush_busy", 32'(busy), 32'd1);
        checkOutput("flush_done_early", 32'(flush_done), 32'd0);
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000);
            checkOutput("drain_busy", 32'(busy), 32'd1);
            checkOutput("drain_flush_done", 32'(flush_done), 32'd0);
        end
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000);
        checkOutput("exit_busy", 32'(busy), 32'd0);
        checkOutput("exit_flush_done", 32'(flush_done), 32'd1);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000);
        checkOutput("idle_flush_done", 32'(flush_done), 32'd0);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0010);
        idleCycles(11, 1'b1);

        $display("[TB] reset with words in flight");
        doReset();
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, rr_all[k]);
        end
        @(negedge clk);
        reset = 1'b1;
        sb_q.delete();
        #1;
        checkOutput("reset_req_ready", 32'(bus_if.req_ready), 32'd0);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000);
        checkOutput("post_reset_out_valid", 32'(bus_if.out_valid), 32'd0);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0001);
        idleCycles(12, 1'b1);

        checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
